// File: rtl/project_switch_ctrl.sv
// project_switch_ctrl
// Sequences the shared user-IO mux between hosted projects. A select request
// floats the pads, holds the outgoing project in reset, moves the mux, holds
// the incoming project in reset and finally releases it and re-enables pads.
module project_switch_ctrl #(
    parameter int NUM_PROJECTS = 8,
    parameter int SEL_W        = 3,
    parameter int DRAIN_CYCLES = 4,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [SEL_W-1:0]        req_sel,
    input  logic                    req_restart,
    output logic                    req_ready,
    output logic [SEL_W-1:0]        active_sel,
    output logic [NUM_PROJECTS-1:0] proj_active,
    output logic [NUM_PROJECTS-1:0] proj_reset_n,
    output logic                    io_oeb_force,
    output logic                    busy,
    output logic                    err_invalid
);

    localparam int MAX_CYC = (DRAIN_CYCLES > HOLD_CYCLES) ? DRAIN_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    // One extra bit so the range check also works when 2**SEL_W == NUM_PROJECTS.
    localparam logic [SEL_W:0]   NUM_P      = (SEL_W + 1)'(NUM_PROJECTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Decode a project index into a one-hot mux/reset vector.
    function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_PROJECTS-1:0] v;
        for (int i = 0; i < NUM_PROJECTS; i++) begin
            v[i] = (sel == SEL_W'(i));
        end
        return v;
    endfunction

    state_t                  state_r,        state_s;
    logic [CNT_W-1:0]        cnt_r,          cnt_s;
    logic [SEL_W-1:0]        active_sel_r,   active_sel_s;
    logic [SEL_W-1:0]        new_sel_r,      new_sel_s;
    logic [NUM_PROJECTS-1:0] proj_active_r,  proj_active_s;
    logic [NUM_PROJECTS-1:0] proj_reset_n_r, proj_reset_n_s;
    logic                    io_oeb_force_r, io_oeb_force_s;
    logic                    err_invalid_r,  err_invalid_s;
    logic                    transfer_s;
    logic                    sel_invalid_s;

    // Handshake and request classification decoded from current state.
    always_comb begin
        req_ready     = (state_r == ST_IDLE);
        busy          = ~req_ready;
        transfer_s    = req_valid & req_ready;
        sel_invalid_s = ({1'b0, req_sel} >= NUM_P);
    end

    // Next-state and next-output logic for the switch sequencer.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        active_sel_s   = active_sel_r;
        new_sel_s      = new_sel_r;
        proj_active_s  = proj_active_r;
        proj_reset_n_s = proj_reset_n_r;
        io_oeb_force_s = io_oeb_force_r;
        err_invalid_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!transfer_s) begin
                    state_s = ST_IDLE;
                end else if (sel_invalid_s) begin
                    // Out-of-range select: report it, leave everything else alone.
                    err_invalid_s = 1'b1;
                end else if ((req_sel == active_sel_r) && !req_restart) begin
                    // Already selected and no restart asked for: nothing to do.
                    state_s = ST_IDLE;
                end else begin
                    new_sel_s      = req_sel;
                    state_s        = ST_DRAIN;
                    cnt_s          = DRAIN_LOAD;
                    io_oeb_force_s = 1'b1;
                    proj_active_s  = {NUM_PROJECTS{1'b0}};
                    proj_reset_n_s = proj_reset_n_r & ~onehot(active_sel_r);
                end
            end

            ST_DRAIN: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    // Old project is quiet: hand the mux to the new one, still in reset.
                    active_sel_s   = new_sel_r;
                    proj_active_s  = onehot(new_sel_r);
                    proj_reset_n_s = proj_reset_n_r & ~onehot(new_sel_r);
                    state_s        = ST_HOLD;
                    cnt_s          = HOLD_LOAD;
                end
            end

            ST_HOLD: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    proj_reset_n_s = onehot(active_sel_r);
                    io_oeb_force_s = 1'b0;
                    state_s        = ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe reset-like hold.
                state_s        = ST_HOLD;
                cnt_s          = HOLD_LOAD;
                proj_active_s  = onehot(active_sel_r);
                proj_reset_n_s = {NUM_PROJECTS{1'b0}};
                io_oeb_force_s = 1'b1;
            end
        endcase
    end

    // State and output registers; reset boots project 0 through the HOLD path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_HOLD;
            cnt_r          <= HOLD_LOAD;
            active_sel_r   <= {SEL_W{1'b0}};
            new_sel_r      <= {SEL_W{1'b0}};
            proj_active_r  <= onehot({SEL_W{1'b0}});
            proj_reset_n_r <= {NUM_PROJECTS{1'b0}};
            io_oeb_force_r <= 1'b1;
            err_invalid_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            active_sel_r   <= active_sel_s;
            new_sel_r      <= new_sel_s;
            proj_active_r  <= proj_active_s;
            proj_reset_n_r <= proj_reset_n_s;
            io_oeb_force_r <= io_oeb_force_s;
            err_invalid_r  <= err_invalid_s;
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        active_sel   = active_sel_r;
        proj_active  = proj_active_r;
        proj_reset_n = proj_reset_n_r;
        io_oeb_force = io_oeb_force_r;
        err_invalid  = err_invalid_r;
    end

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Self-checking bench for project_switch_ctrl with six hosted projects.
module tb_project_switch_ctrl;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic [2:0] req_sel;
    logic       req_restart;
    logic       req_ready;
    logic [2:0] active_sel;
    logic [5:0] proj_active;
    logic [5:0] proj_reset_n;
    logic       io_oeb_force;
    logic       busy;
    logic       err_invalid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] sel;
        logic       restart;
        logic       exp_err;
        int         exp_busy;
        int         exp_drain;
        logic [2:0] exp_active;
        logic [5:0] exp_rst;
        logic [5:0] exp_pa;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];

    project_switch_ctrl #(
        .NUM_PROJECTS(6),
        .SEL_W(3),
        .DRAIN_CYCLES(4),
        .HOLD_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_sel(req_sel),
        .req_restart(req_restart),
        .req_ready(req_ready),
        .active_sel(active_sel),
        .proj_active(proj_active),
        .proj_reset_n(proj_reset_n),
        .io_oeb_force(io_oeb_force),
        .busy(busy),
        .err_invalid(err_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Count sample points (one per clock) until req_ready, noting pad/reset behaviour.
    task automatic wait_ready(input string tag, output int n, output int drain, output int viol);
        n = 0; drain = 0; viol = 0;
        while (!req_ready && n < 200) begin
            n++;
            if (proj_active == 6'h00) drain++;
            if (!io_oeb_force || proj_reset_n != 6'h00 || !busy) viol++;
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 32'(n >= 200), 32'd0);
    endtask

    task automatic run_req(input vec_t v, input string tag);
        vec_t e;
        int n, drain, viol;
        @(negedge clk);
        req_sel = v.sel; req_restart = v.restart; req_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_err"}, 32'(err_invalid), 32'(e.exp_err));
        wait_ready(tag, n, drain, viol);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(e.exp_busy));
        chk({tag, "_drain_cycles"}, 32'(drain), 32'(e.exp_drain));
        chk({tag, "_seq_viol"}, 32'(viol), 32'd0);
        chk({tag, "_active_sel"}, 32'(active_sel), 32'(e.exp_active));
        chk({tag, "_proj_reset_n"}, 32'(proj_reset_n), 32'(e.exp_rst));
        chk({tag, "_proj_active"}, 32'(proj_active), 32'(e.exp_pa));
        chk({tag, "_oeb"}, 32'(io_oeb_force), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_err_clear"}, 32'(err_invalid), 32'd0);
    endtask

    task automatic boot_check(input string tag);
        int n, drain, viol;
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(tag, n, drain, viol);
        chk({tag, "_hold_cycles"}, 32'(n), 32'd16);
        chk({tag, "_seq_viol"}, 32'(viol), 32'd0);
        chk({tag, "_pa_during"}, 32'(drain), 32'd0);
        chk({tag, "_proj_reset_n"}, 32'(proj_reset_n), 32'h01);
        chk({tag, "_oeb"}, 32'(io_oeb_force), 32'd0);
        chk({tag, "_active_sel"}, 32'(active_sel), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_rst_n"}, 32'(proj_reset_n), 32'h00);
        chk({tag, "_oeb"}, 32'(io_oeb_force), 32'd1);
        chk({tag, "_active_sel"}, 32'(active_sel), 32'd0);
        chk({tag, "_proj_active"}, 32'(proj_active), 32'h01);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_err"}, 32'(err_invalid), 32'd0);
    endtask

    initial begin
        int n, drain, viol;
        vec_t v0;

        //          sel   rst   err   busy drain act   rst_n  active
        vecs[0] = '{3'd3, 1'b0, 1'b0, 20, 4, 3'd3, 6'h08, 6'h08};
        vecs[1] = '{3'd6, 1'b0, 1'b1, 0,  0, 3'd3, 6'h08, 6'h08};
        vecs[2] = '{3'd7, 1'b1, 1'b1, 0,  0, 3'd3, 6'h08, 6'h08};
        vecs[3] = '{3'd3, 1'b0, 1'b0, 0,  0, 3'd3, 6'h08, 6'h08};
        vecs[4] = '{3'd3, 1'b1, 1'b0, 20, 4, 3'd3, 6'h08, 6'h08};
        vecs[5] = '{3'd0, 1'b0, 1'b0, 20, 4, 3'd0, 6'h01, 6'h01};
        vecs[6] = '{3'd5, 1'b1, 1'b0, 20, 4, 3'd5, 6'h20, 6'h20};

        clk = 1'b0; reset_n = 1'b0;
        req_valid = 1'b0; req_sel = 3'd0; req_restart = 1'b0;
        #12;
        reset_values("reset");
        boot_check("boot");

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Request held high while a switch to 2 is in progress.
        @(negedge clk);
        req_sel = 3'd2; req_restart = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_sel = 3'd5;
        chk("hold_ready_low", 32'(req_ready), 32'd0);
        wait_ready("hold_a", n, drain, viol);
        chk("hold_a_cycles", 32'(n), 32'd20);
        chk("hold_a_active", 32'(active_sel), 32'd2);
        chk("hold_a_rst", 32'(proj_reset_n), 32'h04);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold_b_accepted", 32'(req_ready), 32'd0);
        wait_ready("hold_b", n, drain, viol);
        chk("hold_b_cycles", 32'(n), 32'd20);
        chk("hold_b_active", 32'(active_sel), 32'd5);
        chk("hold_b_rst", 32'(proj_reset_n), 32'h20);
        chk("hold_b_pa", 32'(proj_active), 32'h20);

        // Reset during DRAIN of a 0->3 switch discards the pending select.
        v0 = '{3'd0, 1'b0, 1'b0, 20, 4, 3'd0, 6'h01, 6'h01};
        run_req(v0, "to0");
        @(negedge clk);
        req_sel = 3'd3; req_restart = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_drain_pa", 32'(proj_active), 32'h00);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        reset_values("midreset");
        boot_check("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
